// File: rtl/msk_aes_mixcol_seq_pkg.sv
// Shared definitions for the masked AES MixColumns unit:
// mode codes, FSM states, GF(2^8) reduction constant and xtime.
package msk_aes_mixcol_seq_pkg;

    localparam logic [1:0] MC_FWD = 2'd0;
    localparam logic [1:0] MC_INV = 2'd1;
    localparam logic [1:0] MC_BYP = 2'd2;

    localparam logic [7:0] AES_RED = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mc_fsm_e;

    // Multiply by x in GF(2^8); linear, so it applies to each share alone.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_RED : 8'h00);
    endfunction

endpackage

// File: rtl/msk_aes_mc_col.sv
// Combinational per-share MixColumns / InvMixColumns / bypass
// on one shared 32*d-bit column.
module msk_aes_mc_col
    import msk_aes_mixcol_seq_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [32*d-1:0] col_i,
    input  logic [1:0]      mode_i,
    output logic [32*d-1:0] col_o
);

    // Forward row: 02*b0 ^ 03*b1 ^ b2 ^ b3.
    function automatic logic [7:0] mc_row(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    endfunction

    // Inverse row: 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3 via x2/x4/x8 chains.
    function automatic logic [7:0] inv_row(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        logic [7:0] p2, p4, p8;
        logic [7:0] acc;
        p2  = xtime(b0);
        p4  = xtime(p2);
        p8  = xtime(p4);
        acc = p8 ^ p4 ^ p2;
        p2  = xtime(b1);
        p4  = xtime(p2);
        p8  = xtime(p4);
        acc = acc ^ p8 ^ p2 ^ b1;
        p2  = xtime(b2);
        p4  = xtime(p2);
        p8  = xtime(p4);
        acc = acc ^ p8 ^ p4 ^ b2;
        p2  = xtime(b3);
        p4  = xtime(p2);
        p8  = xtime(p4);
        acc = acc ^ p8 ^ b3;
        return acc;
    endfunction

    for (genvar s = 0; s < d; s++) begin : g_share
        logic [3:0][7:0] a;
        logic [3:0][7:0] y;

        for (genvar r = 0; r < 4; r++) begin : g_row
            for (genvar i = 0; i < 8; i++) begin : g_bit
                assign a[r][i] = col_i[r*8*d + i*d + s];
                assign col_o[r*8*d + i*d + s] = y[r][i];
            end
        end

        // Transform this share's four bytes; unknown modes pass through.
        always_comb begin
            y = a;
            case (mode_i)
                MC_FWD: begin
                    y[0] = mc_row(a[0], a[1], a[2], a[3]);
                    y[1] = mc_row(a[1], a[2], a[3], a[0]);
                    y[2] = mc_row(a[2], a[3], a[0], a[1]);
                    y[3] = mc_row(a[3], a[0], a[1], a[2]);
                end
                MC_INV: begin
                    y[0] = inv_row(a[0], a[1], a[2], a[3]);
                    y[1] = inv_row(a[1], a[2], a[3], a[0]);
                    y[2] = inv_row(a[2], a[3], a[0], a[1]);
                    y[3] = inv_row(a[3], a[0], a[1], a[2]);
                end
                default: y = a;
            endcase
        end
    end

endmodule

// File: rtl/msk_aes_mixcol_seq.sv
// Sequential masked MixColumns: one column per cycle, in place,
// with valid/ready on both sides.
module msk_aes_mixcol_seq
    import msk_aes_mixcol_seq_pkg::*;
#(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [128*d-1:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [128*d-1:0] out_state
);

    localparam int CW = 32 * d;

    mc_fsm_e          fsm_q, fsm_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       mode_q, mode_d;
    logic [128*d-1:0] state_q, state_d;
    logic [CW-1:0]    col_in;
    logic [CW-1:0]    col_out;

    assign col_in = state_q[col_q*CW +: CW];

    msk_aes_mc_col #(.d(d)) u_col (
        .col_i  (col_in),
        .mode_i (mode_q),
        .col_o  (col_out)
    );

    // Next-state: load on accept, rewrite one column per RUN cycle.
    always_comb begin
        fsm_d   = fsm_q;
        col_d   = col_q;
        mode_d  = mode_q;
        state_d = state_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_state;
                    mode_d  = in_mode;
                    col_d   = 2'd0;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d[col_q*CW +: CW] = col_out;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset clearing all data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            col_q   <= 2'd0;
            mode_q  <= MC_FWD;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign out_state = state_q;

endmodule

// File: tb/tb_msk_aes_mixcol_seq.sv
// Self-checking bench for msk_aes_mixcol_seq: directed vectors,
// scoreboard queue, latency, backpressure and reset checks.
module tb_msk_aes_mixcol_seq;

    localparam int D = 2;

    typedef struct {
        logic [127:0]          exp;
        logic [127:0]          plain;
        logic [D-1:0][127:0]   in_sh;
    } sb_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [128*D-1:0] in_state;
    logic             out_valid;
    logic             out_ready;
    logic [128*D-1:0] out_state;

    int  tests;
    int  fails;
    sb_t sb[$];

    msk_aes_mixcol_seq #(.d(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] p, input logic [1:0] m);
        logic [7:0]   k [4];
        logic [127:0] o;
        logic [7:0]   acc;
        if (m == 2'd0) begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end else begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end
        if (m >= 2'd2) return p;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(k[(j - r + 4) % 4], p[(4*c + j)*8 +: 8]);
                end
                o[(4*c + r)*8 +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] all_cols(input logic [31:0] w);
        logic [127:0] v;
        for (int c = 0; c < 4; c++) begin
            v[c*32 +: 8]      = w[31:24];
            v[c*32 + 8 +: 8]  = w[23:16];
            v[c*32 + 16 +: 8] = w[15:8];
            v[c*32 + 24 +: 8] = w[7:0];
        end
        return v;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [128*D-1:0] pack(input logic [D-1:0][127:0] sh);
        logic [128*D-1:0] v;
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 8; i++)
                for (int s = 0; s < D; s++)
                    v[k*8*D + i*D + s] = sh[s][k*8 + i];
        return v;
    endfunction

    function automatic logic [127:0] share_of(input logic [128*D-1:0] v, input int s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 8; i++)
                r[k*8 + i] = v[k*8*D + i*D + s];
        return r;
    endfunction

    function automatic logic [127:0] unmask(input logic [128*D-1:0] v);
        logic [127:0] r;
        r = '0;
        for (int s = 0; s < D; s++) r = r ^ share_of(v, s);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] p, input logic [1:0] m);
        sb_t e;
        logic [127:0] acc;
        int w;
        acc = p;
        for (int s = 1; s < D; s++) begin
            e.in_sh[s] = rnd128();
            acc = acc ^ e.in_sh[s];
        end
        e.in_sh[0] = acc;
        e.plain = p;
        e.exp = model(p, m);
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 512'(in_ready), 512'(1));
        in_valid = 1'b1;
        in_mode  = m;
        in_state = pack(e.in_sh);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 2'($urandom);
        in_state = pack({D{rnd128()}}) ^ {D{rnd128()}};
        sb.push_back(e);
    endtask

    task automatic recv(input int hold);
        sb_t e;
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 20);
        chk("latency", 512'(cyc), 512'(4));
        chk("out_valid", 512'(out_valid), 512'(1));
        if (sb.size() == 0) begin
            chk("sb_nonempty", 512'(0), 512'(1));
            return;
        end
        e = sb.pop_front();
        chk("data", 512'(unmask(out_state)), 512'(e.exp));
        for (int s = 0; s < D; s++) begin
            chk($sformatf("share%0d_masked", s),
                512'(share_of(out_state, s) == e.exp),
                512'(e.in_sh[s] == e.plain));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 512'(out_valid), 512'(1));
            chk("bp_in_ready", 512'(in_ready), 512'(0));
            chk("bp_data", 512'(unmask(out_state)), 512'(e.exp));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_valid", 512'(out_valid), 512'(0));
        chk("post_in_ready", 512'(in_ready), 512'(1));
    endtask

    initial begin
        logic [127:0] p;
        logic [127:0] q;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_state  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_state", 512'(out_state), 512'(0));

        send(all_cols(32'hdb135345), 2'd0);
        recv(0);

        p = all_cols(32'hdb135345);
        p[63:32] = {8'h5c, 8'h22, 8'h0a, 8'hf2};
        q = all_cols(32'h8e4da1bc);
        q[63:32] = {8'h9d, 8'h58, 8'hdc, 8'h9f};
        send(p, 2'd0);
        recv(0);
        chk("const_mc_model", 512'(model(p, 2'd0)), 512'(q));

        send(all_cols(32'h8e4da1bc), 2'd1);
        sb[0].exp = all_cols(32'hdb135345);
        recv(0);

        p = rnd128();
        send(p, 2'd0);
        recv(0);
        send(model(p, 2'd0), 2'd1);
        sb[0].exp = p;
        recv(0);

        p = rnd128();
        send(p, 2'd2);
        sb[0].exp = p;
        recv(0);
        p = rnd128();
        send(p, 2'd3);
        sb[0].exp = p;
        recv(0);

        send(rnd128(), 2'd1);
        recv(10);

        out_ready = 1'b1;
        send(rnd128(), 2'd0);
        recv(0);

        send(rnd128(), 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", 512'(out_valid), 512'(0));
        chk("midrst_in_ready", 512'(in_ready), 512'(1));
        chk("midrst_out_state", 512'(out_state), 512'(0));
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("midrst_quiet", 512'(out_valid), 512'(0));
        end
        send(all_cols(32'hdb135345), 2'd0);
        recv(0);

        for (int n = 0; n < 6; n++) begin
            send(rnd128(), 2'($urandom_range(0, 3)));
            recv(n % 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
